msrv32_dmem_access_ctrl: RTL and testbench
==========================================

Name: msrv32_dmem_access_ctrl

Overview:
- Sequences data-memory loads and stores for the MSRV32 pipeline.
- Accepts one access per request from the address/rs2 path, drives the word-aligned bus request with byte mask and replicated store data, and stalls the pipeline until abh_resp_in completes the transfer.
- Captures load data and the address low bits, which feed msrv32_load_unit and the write-back mux.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of WAIT cycles before the access is abandoned. Legal range 1..65535.

Ports:
- ms_riscv32_mp_clk_in  in  1  clock; all state changes on rising edge.
- ms_riscv32_mp_rst_n_in  in  1  reset; asynchronous, active-low.
- mem_req_valid_in  in  1  load/store instruction present this cycle.
- mem_wr_req_in  in  1  1 = store, 0 = load.
- iadder_in  in  32  effective byte address.
- rs2_in  in  32  store data.
- load_stre_in  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- flush_in  in  1  pipeline kill.
- abh_resp_in  in  1  bus transfer complete; read data valid when high.
- ms_riscv32_mp_dmdata_in  in  32  bus read data.
- ms_riscv32_mp_dmaddr_out  out  32  word-aligned address, {addr[31:2],2'b00}.
- ms_riscv32_mp_dmreq_out  out  1  request strobe, high exactly one cycle per access.
- ms_riscv32_mp_dmwr_req_out  out  1  store qualifier.
- ms_riscv32_mp_dmwr_mask_out  out  4  byte enables; 0000 for loads.
- ms_riscv32_mp_dmdata_out  out  32  replicated store data.
- stall_out  out  1  pipeline hold.
- load_data_out  out  32  captured read word.
- iadder_u1_to_lu_out  out  2  latched addr[1:0] for the load unit.
- load_done_out  out  1  one-cycle pulse when load_data_out is updated.
- misaligned_out  out  1  one-cycle exception pulse.
- timeout_err_out  out  1  one-cycle bus-error pulse.

Behaviour:
- Reset (asynchronous, usable mid-operation): state goes to IDLE immediately. All outputs, latches and the counter are 0.
- Acceptance condition in IDLE: mem_req_valid_in & !flush_in.
- Alignment check on accept:
  - Word requires addr[1:0]==00.
  - Half requires addr[0]==0.
  - Byte is always aligned.
- Misaligned accept: no bus request, state stays IDLE, misaligned_out pulses the next cycle, stall_out stays 0.
- Aligned accept:
  - Latch address, mask, store data and the kill flag (cleared).
  - Go to ACCESS next cycle.
  - stall_out = 1 combinationally in the accept cycle.
- ACCESS:
  - dmreq_out=1 and dmwr_req_out=mem_wr_req; outputs are driven from the latches.
  - If abh_resp_in=1 this cycle, the access completes (zero-wait). Otherwise go to WAIT and clear the counter.
- WAIT:
  - dmreq_out=0; address, mask and data are held stable.
  - If abh_resp_in=1, the access completes.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without a response: next state IDLE, timeout_err_out pulses the next cycle, no load_done.
- stall_out:
  - 1 in WAIT and in ACCESS.
  - 0 in the cycle abh_resp_in is sampled high, so the pipeline advances at that edge.
  - Zero-wait access therefore stalls exactly 1 cycle; N wait cycles stall N+1 cycles.
- Completion: next state IDLE. For a load that is not killed, load_data_out <= dmdata_in and load_done_out pulses the next cycle. load_data_out holds until the next completed load.
- Mask and store data:
  - Byte: mask 0001<<addr[1:0], data {4{rs2[7:0]}}.
  - Half: mask 0011<<addr[1:0], data {2{rs2[15:0]}}.
  - Word: mask 1111, data rs2.
- flush_in:
  - In IDLE it blocks acceptance.
  - In ACCESS/WAIT the transfer is not aborted. The kill flag is set, stall is held until the response, and a killed load suppresses load_done_out.
  - A store issued before a flush completes normally.
- abh_resp_in is ignored in IDLE.
- No new request is accepted in the completion cycle; the earliest next accept is the following IDLE cycle.

Decomposition:
- Package msrv32_dmem_pkg: state encoding (IDLE, ACCESS, WAIT), size codes (SZ_BYTE, SZ_HALF, SZ_WORD), and the counter-width function clog2(TIMEOUT_CYCLES+1).
- Sub-module msrv32_store_align: combinational size/addr/rs2 -> mask, replicated data and misaligned flag. Instantiated once.

Test Plan:
1. Word store to 0x1000_0004, rs2=0xDEADBEEF, resp in ACCESS cycle -> dmaddr 0x1000_0004, mask 1111, data 0xDEADBEEF; dmreq 1 cycle; stall 1 cycle.
2. Byte store 0xA5 to 0x1000_0003, zero-wait -> mask 1000, data 0xA5A5A5A5, dmaddr 0x1000_0000.
3. Half load from 0x0000_2002, resp after 3 WAIT cycles with dmdata 0x12345678 -> stall 5 cycles (accept, ACCESS, 3 WAIT; 0 in resp cycle), load_done pulse next cycle, load_data 0x12345678, iadder_u1_to_lu 10, mask 0000.
4. Word load from 0x0000_2001 -> no dmreq, misaligned pulse next cycle, stall 0; a half load to 0x2001 behaves the same.
5. TIMEOUT_CYCLES=4, store with no response -> 4 WAIT cycles, timeout_err pulse, IDLE, stall 0, next request accepted normally.
6. Load with flush_in during WAIT, resp 2 cycles later -> stall held until resp, no load_done, load_data unchanged. Separately, reset asserted in WAIT -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/msrv32_dmem_pkg.sv
`default_nettype none
// ==========================================================================
// msrv32_dmem_pkg : shared encodings for the MSRV32 data-memory controller
// Revision: 1.0
// ==========================================================================
package msrv32_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msrv32_store_align.sv
`default_nettype none
// ==========================================================================
// msrv32_store_align : byte enables, lane-replicated store data, alignment
// Revision: 1.0
// ==========================================================================
module msrv32_store_align
  import msrv32_dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rs2_i,
  output logic [3:0]  mask_o,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  always_comb begin
    mask_o       = 4'b1111;
    data_o       = rs2_i;
    misaligned_o = |addr_lo_i;
    case (size_i)
      SZ_BYTE: begin
        mask_o       = 4'b0001 << addr_lo_i;
        data_o       = {4{rs2_i[7:0]}};
        misaligned_o = 1'b0;
      end
      SZ_HALF: begin
        mask_o       = 4'b0011 << addr_lo_i;
        data_o       = {2{rs2_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      // SZ_WORD and the reserved code 11 both behave as a word access
      default: begin
        mask_o       = 4'b1111;
        data_o       = rs2_i;
        misaligned_o = |addr_lo_i;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/msrv32_dmem_access_ctrl.sv
`default_nettype none
// ==========================================================================
// msrv32_dmem_access_ctrl : load/store sequencer with stall, timeout, misalign
// Revision: 1.0
// ==========================================================================
module msrv32_dmem_access_ctrl
  import msrv32_dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        mem_req_valid_in,
  input  logic        mem_wr_req_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic [1:0]  load_stre_in,
  input  logic        flush_in,
  input  logic        abh_resp_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic        ms_riscv32_mp_dmreq_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic [1:0]  iadder_u1_to_lu_out,
  output logic        load_done_out,
  output logic        misaligned_out,
  output logic        timeout_err_out
);

  localparam int              CNT_W    = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic [3:0]         mask_q, mask_d;
  logic               wr_q, wr_d;
  logic               kill_q, kill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        load_data_q, load_data_d;
  logic               load_done_q, load_done_d;
  logic               misaligned_q, misaligned_d;
  logic               timeout_q, timeout_d;

  logic [3:0]         sa_mask;
  logic [31:0]        sa_data;
  logic               sa_misaligned;
  logic               accept;
  logic               busy;
  logic               dmreq;
  logic               stall;

  msrv32_store_align u_store_align (
    .size_i       (load_stre_in),
    .addr_lo_i    (iadder_in[1:0]),
    .rs2_i        (rs2_in),
    .mask_o       (sa_mask),
    .data_o       (sa_data),
    .misaligned_o (sa_misaligned)
  );

  assign accept = (state_q == IDLE) && mem_req_valid_in && !flush_in;
  assign busy   = (state_q == ACCESS) || (state_q == WAIT);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    mask_d       = mask_q;
    wr_d         = wr_q;
    kill_d       = kill_q;
    cnt_d        = cnt_q;
    load_data_d  = load_data_q;
    load_done_d  = 1'b0;
    misaligned_d = 1'b0;
    timeout_d    = 1'b0;
    dmreq        = 1'b0;
    stall        = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (sa_misaligned) begin
            misaligned_d = 1'b1;
          end else begin
            addr_d  = iadder_in;
            mask_d  = mem_wr_req_in ? sa_mask : 4'b0000;
            data_d  = sa_data;
            wr_d    = mem_wr_req_in;
            kill_d  = 1'b0;
            stall   = 1'b1;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        dmreq   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A flush during a bus transfer only marks it killed; the transfer runs on.
    if (busy) begin
      stall  = 1'b1;
      kill_d = kill_q | flush_in;
    end

    if (busy && abh_resp_in) begin
      stall     = 1'b0;
      state_d   = IDLE;
      timeout_d = 1'b0;
      cnt_d     = cnt_q;
      if (!wr_q && !(kill_q || flush_in)) begin
        load_data_d = ms_riscv32_mp_dmdata_in;
        load_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      wr_q         <= 1'b0;
      kill_q       <= 1'b0;
      cnt_q        <= '0;
      load_data_q  <= '0;
      load_done_q  <= 1'b0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      wr_q         <= wr_d;
      kill_q       <= kill_d;
      cnt_q        <= cnt_d;
      load_data_q  <= load_data_d;
      load_done_q  <= load_done_d;
      misaligned_q <= misaligned_d;
      timeout_q    <= timeout_d;
    end
  end

  assign ms_riscv32_mp_dmaddr_out    = {addr_q[31:2], 2'b00};
  assign ms_riscv32_mp_dmreq_out     = dmreq;
  assign ms_riscv32_mp_dmwr_req_out  = wr_q && busy;
  assign ms_riscv32_mp_dmwr_mask_out = mask_q;
  assign ms_riscv32_mp_dmdata_out    = data_q;
  assign stall_out                   = stall;
  assign load_data_out               = load_data_q;
  assign iadder_u1_to_lu_out         = addr_q[1:0];
  assign load_done_out               = load_done_q;
  assign misaligned_out              = misaligned_q;
  assign timeout_err_out             = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_msrv32_dmem_access_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_msrv32_dmem_access_ctrl : scoreboard bench for the dmem access controller
// Revision: 1.0
// ==========================================================================
module tb_msrv32_dmem_access_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        wr;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, wr_req, flush, resp;
  logic [31:0] iadder, rs2, dmdata_in;
  logic [1:0]  lsz;

  logic [31:0] dmaddr, dmdata_out, load_data;
  logic        dmreq, dmwr, stall, load_done, misaligned, timeout_err;
  logic [3:0]  mask;
  logic [1:0]  u1;

  int total = 0;
  int bad   = 0;

  bus_t        exp_bus[$];
  logic [33:0] exp_ld[$];
  int          exp_exc[$];
  int          exp_stall[$];

  always #5 clk = ~clk;

  msrv32_dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_n_in      (rst_n),
    .mem_req_valid_in            (valid),
    .mem_wr_req_in               (wr_req),
    .iadder_in                   (iadder),
    .rs2_in                      (rs2),
    .load_stre_in                (lsz),
    .flush_in                    (flush),
    .abh_resp_in                 (resp),
    .ms_riscv32_mp_dmdata_in     (dmdata_in),
    .ms_riscv32_mp_dmaddr_out    (dmaddr),
    .ms_riscv32_mp_dmreq_out     (dmreq),
    .ms_riscv32_mp_dmwr_req_out  (dmwr),
    .ms_riscv32_mp_dmwr_mask_out (mask),
    .ms_riscv32_mp_dmdata_out    (dmdata_out),
    .stall_out                   (stall),
    .load_data_out               (load_data),
    .iadder_u1_to_lu_out         (u1),
    .load_done_out               (load_done),
    .misaligned_out              (misaligned),
    .timeout_err_out             (timeout_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents an event.
  int run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      if (stall) begin
        run++;
      end else if (run > 0) begin
        if (exp_stall.size() == 0) chk("spurious_stall_run", 64'(run), 64'd0);
        else chk("stall_len", 64'(run), 64'(exp_stall.pop_front()));
        run = 0;
      end
      if (dmreq) begin
        if (exp_bus.size() == 0) begin
          chk("spurious_dmreq", {63'd0, dmreq}, 64'd0);
        end else begin
          bus_t e;
          e = exp_bus.pop_front();
          chk("dmaddr", 64'(dmaddr), 64'(e.addr));
          chk("dmmask", 64'(mask), 64'(e.mask));
          chk("dmdata", 64'(dmdata_out), 64'(e.data));
          chk("dmwr", 64'(dmwr), 64'(e.wr));
        end
      end
      if (load_done) begin
        if (exp_ld.size() == 0) chk("spurious_load_done", {63'd0, load_done}, 64'd0);
        else chk("load_result", 64'({u1, load_data}), 64'(exp_ld.pop_front()));
      end
      if (misaligned) begin
        if (exp_exc.size() == 0) chk("spurious_misaligned", {63'd0, misaligned}, 64'd0);
        else chk("exc_misaligned", 64'd1, 64'(exp_exc.pop_front()));
      end
      if (timeout_err) begin
        if (exp_exc.size() == 0) chk("spurious_timeout", {63'd0, timeout_err}, 64'd0);
        else chk("exc_timeout", 64'd2, 64'(exp_exc.pop_front()));
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic fl);
    @(posedge clk); #1;
    valid = 1'b1; wr_req = w; iadder = a; rs2 = d; lsz = s; flush = fl;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
  endtask

  // nores = cycles after the accept cycle with no response; fl_at = which of them flushes
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, input int nores, input logic [31:0] rdata,
                        input int fl_at);
    issue(w, a, d, s, 1'b0);
    for (int i = 0; i < nores; i++) begin
      resp = 1'b0; flush = (i == fl_at); dmdata_in = $urandom;
      @(posedge clk); #1;
    end
    flush = 1'b0; resp = 1'b1; dmdata_in = rdata;
    @(posedge clk); #1;
    resp = 1'b0; dmdata_in = $urandom;
  endtask

  task automatic check_all_zero();
    chk("rst_dmaddr", 64'(dmaddr), 64'd0);
    chk("rst_dmdata", 64'(dmdata_out), 64'd0);
    chk("rst_load_data", 64'(load_data), 64'd0);
    chk("rst_ctrl", 64'({dmreq, dmwr, mask, stall, u1, load_done, misaligned, timeout_err}), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1; valid = 1'b0; wr_req = 1'b0; flush = 1'b0; resp = 1'b0;
    iadder = '0; rs2 = '0; lsz = 2'b00; dmdata_in = '0;
    #1 rst_n = 1'b0;
    #2 check_all_zero();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // word store, zero-wait
    exp_bus.push_back('{32'h1000_0004, 4'b1111, 32'hDEAD_BEEF, 1'b1}); exp_stall.push_back(1);
    access(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 2'b10, 0, 32'h0, -1);
    // byte store to lane 3
    exp_bus.push_back('{32'h1000_0000, 4'b1000, 32'hA5A5_A5A5, 1'b1}); exp_stall.push_back(1);
    access(1'b1, 32'h1000_0003, 32'h1234_56A5, 2'b00, 0, 32'h0, -1);
    // half store to upper half, one wait
    exp_bus.push_back('{32'h1000_0000, 4'b1100, 32'hBEEF_BEEF, 1'b1}); exp_stall.push_back(2);
    access(1'b1, 32'h1000_0002, 32'hCAFE_BEEF, 2'b01, 1, 32'h0, -1);
    // half load, 3 WAIT cycles before response
    exp_bus.push_back('{32'h0000_2000, 4'b0000, 32'h0, 1'b0}); exp_stall.push_back(5);
    exp_ld.push_back({2'b10, 32'h1234_5678});
    access(1'b0, 32'h0000_2002, 32'h0, 2'b01, 4, 32'h1234_5678, -1);

    // misaligned word, half, and reserved-size accesses
    exp_exc.push_back(1); issue(1'b0, 32'h0000_2001, 32'h0, 2'b10, 1'b0);
    exp_exc.push_back(1); issue(1'b0, 32'h0000_2001, 32'h0, 2'b01, 1'b0);
    exp_exc.push_back(1); issue(1'b1, 32'h0000_2002, 32'h0, 2'b11, 1'b0);
    // byte load at odd address is aligned
    exp_bus.push_back('{32'h0000_2000, 4'b0000, 32'h0, 1'b0}); exp_stall.push_back(1);
    exp_ld.push_back({2'b01, 32'h0BAD_F00D});
    access(1'b0, 32'h0000_2001, 32'h0, 2'b00, 0, 32'h0BAD_F00D, -1);

    // flush in IDLE blocks acceptance; response in IDLE is ignored
    issue(1'b1, 32'h0000_5000, 32'h1, 2'b10, 1'b1);
    @(posedge clk); #1 resp = 1'b1; dmdata_in = 32'hFFFF_FFFF;
    @(posedge clk); #1 resp = 1'b0;

    // timeout after 4 WAIT cycles, then a normal store
    exp_bus.push_back('{32'h0000_3000, 4'b1111, 32'h55AA_55AA, 1'b1}); exp_stall.push_back(6);
    exp_exc.push_back(2);
    issue(1'b1, 32'h0000_3000, 32'h55AA_55AA, 2'b10, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    exp_bus.push_back('{32'h0000_3004, 4'b1111, 32'h0102_0304, 1'b1}); exp_stall.push_back(1);
    access(1'b1, 32'h0000_3004, 32'h0102_0304, 2'b10, 0, 32'h0, -1);

    // load killed in WAIT: stall held, no load_done, load data unchanged
    exp_bus.push_back('{32'h0000_4000, 4'b0000, 32'h0, 1'b0}); exp_stall.push_back(4);
    access(1'b0, 32'h0000_4000, 32'h0, 2'b10, 3, 32'h7777_7777, 1);
    @(posedge clk); #1;
    chk("load_data_after_kill", 64'(load_data), 64'h0BAD_F00D);
    // store flushed in ACCESS still completes
    exp_bus.push_back('{32'h0000_5000, 4'b0011, 32'h9966_9966, 1'b1}); exp_stall.push_back(3);
    access(1'b1, 32'h0000_5000, 32'h1234_9966, 2'b01, 2, 32'h0, 0);

    // asynchronous reset in WAIT
    exp_bus.push_back('{32'h0000_6000, 4'b0000, 32'h0, 1'b0});
    issue(1'b0, 32'h0000_6000, 32'h0, 2'b10, 1'b0);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check_all_zero();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // recovery: normal load after reset
    exp_bus.push_back('{32'h0000_7000, 4'b0000, 32'h0, 1'b0}); exp_stall.push_back(2);
    exp_ld.push_back({2'b00, 32'hFEED_FACE});
    access(1'b0, 32'h0000_7000, 32'h0, 2'b10, 1, 32'hFEED_FACE, -1);

    repeat (4) @(posedge clk);
    #1;
    chk("bus_pending", 64'(exp_bus.size()), 64'd0);
    chk("load_pending", 64'(exp_ld.size()), 64'd0);
    chk("exc_pending", 64'(exp_exc.size()), 64'd0);
    chk("stall_pending", 64'(exp_stall.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
